// File: rtl/sprite_pop_sequencer.sv
// Frame-synchronous sprite controller: horizontal bounce motion plus a
// timed "pop" image select with cooldown. Every state change lands on the
// start of vertical blanking, so the renderer never sees a mid-frame update.
module sprite_pop_sequencer #(
    parameter int SCREEN_W        = 1280,
    parameter int SCREEN_H        = 720,
    parameter int SPRITE_W        = 256,
    parameter int SPEED           = 2,
    parameter int X_START         = 0,
    parameter int Y_POS           = 100,
    parameter int HOLD_FRAMES     = 30,
    parameter int COOLDOWN_FRAMES = 15
) (
    input  logic        pixel_clk_in,
    input  logic        rst_n_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        enable_in,
    input  logic        trigger_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        pop_out,
    output logic        busy_out,
    output logic        frame_tick_out
);

    localparam int XMAX    = SCREEN_W - SPRITE_W;
    // A start position beyond the right limit is pulled back onto the edge.
    localparam int X_INIT  = (X_START > XMAX) ? XMAX : X_START;
    localparam int CNT_MAX = (HOLD_FRAMES > COOLDOWN_FRAMES) ? HOLD_FRAMES : COOLDOWN_FRAMES;
    localparam int CNT_W   = ($clog2(CNT_MAX + 1) > 8) ? $clog2(CNT_MAX + 1) : 8;

    localparam logic [11:0]      XMAX_W    = 12'(XMAX);
    localparam logic [10:0]      XMAX_X    = 11'(XMAX);
    localparam logic [10:0]      X_INIT_X  = 11'(X_INIT);
    localparam logic [11:0]      SPEED_W   = 12'(SPEED);
    localparam logic [9:0]       TICK_LINE = 10'(SCREEN_H);
    localparam logic [9:0]       Y_POS_V   = 10'(Y_POS);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_FRAMES - 1);
    localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_COOL = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             pop_r, pop_s;
    logic             busy_r, busy_s;
    logic             pend_r, pend_s;
    logic [10:0]      x_r, x_s;
    logic             dir_left_r, dir_left_s;
    logic             tick_s, tick_r;
    logic [9:0]       y_r;
    logic [11:0]      x_ext_s, x_up_s, x_dn_s;

    // Frame tick: first pixel of the first blanking line.
    always_comb begin
        tick_s = (hcount_in == 11'd0) && (vcount_in == TICK_LINE);
    end

    // Pop FSM next state: counter only advances on the frame tick.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        pop_s   = pop_r;
        case (state_r)
            ST_IDLE: begin
                if (tick_s && (pend_r || trigger_in)) begin
                    state_s = ST_POP;
                    cnt_s   = HOLD_LOAD;
                    pop_s   = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_POP: begin
                if (tick_s) begin
                    if (cnt_r == '0) begin
                        state_s = ST_COOL;
                        cnt_s   = COOL_LOAD;
                        pop_s   = 1'b0;
                    end else begin
                        cnt_s = cnt_r - CNT_ONE;
                    end
                end else begin
                    state_s = ST_POP;
                end
            end
            ST_COOL: begin
                if (tick_s) begin
                    if (cnt_r == '0) begin
                        state_s = ST_IDLE;
                    end else begin
                        cnt_s = cnt_r - CNT_ONE;
                    end
                end else begin
                    state_s = ST_COOL;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
                pop_s   = 1'b0;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // Trigger latch: remembers a request seen in IDLE until the next tick.
    always_comb begin
        if (tick_s) begin
            pend_s = 1'b0;
        end else if ((state_r == ST_IDLE) && trigger_in) begin
            pend_s = 1'b1;
        end else begin
            pend_s = pend_r;
        end
    end

    // Horizontal motion with edge bounce; 12-bit arithmetic avoids wrap.
    always_comb begin
        x_s        = x_r;
        dir_left_s = dir_left_r;
        x_ext_s    = {1'b0, x_r};
        x_up_s     = x_ext_s + SPEED_W;
        x_dn_s     = x_ext_s - SPEED_W;
        if (tick_s && enable_in && (state_r != ST_POP)) begin
            if (!dir_left_r) begin
                if (x_up_s >= XMAX_W) begin
                    x_s        = XMAX_X;
                    dir_left_s = 1'b1;
                end else begin
                    x_s = x_up_s[10:0];
                end
            end else begin
                if (x_ext_s <= SPEED_W) begin
                    x_s        = 11'd0;
                    dir_left_s = 1'b0;
                end else begin
                    x_s = x_dn_s[10:0];
                end
            end
        end else begin
            x_s        = x_r;
            dir_left_s = dir_left_r;
        end
    end

    // State, position and output registers; reset drops pop at once.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            pop_r      <= 1'b0;
            busy_r     <= 1'b0;
            pend_r     <= 1'b0;
            x_r        <= X_INIT_X;
            dir_left_r <= 1'b0;
            tick_r     <= 1'b0;
            y_r        <= Y_POS_V;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            pop_r      <= pop_s;
            busy_r     <= busy_s;
            pend_r     <= pend_s;
            x_r        <= x_s;
            dir_left_r <= dir_left_s;
            tick_r     <= tick_s;
            y_r        <= Y_POS_V;
        end
    end

    assign x_out          = x_r;
    assign y_out          = y_r;
    assign pop_out        = pop_r;
    assign busy_out       = busy_r;
    assign frame_tick_out = tick_r;

endmodule

// File: tb/tb_sprite_pop_sequencer.sv
// Directed bench for sprite_pop_sequencer: a vector table for the frame-by-
// frame behaviour plus hand sequences for reset and the full bounce sweep.
module tb_sprite_pop_sequencer;

    logic        clk;
    logic        rst_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        enable;
    logic        trigger;
    logic [10:0] x;
    logic [9:0]  y;
    logic        pop;
    logic        busy;
    logic        ftick;
    logic [10:0] x_c;
    logic [9:0]  y_c;
    logic        pop_c;
    logic        busy_c;
    logic        ftick_c;

    int n_checks = 0;
    int n_fail   = 0;

    sprite_pop_sequencer #(
        .SCREEN_W(1280), .SCREEN_H(720), .SPRITE_W(256), .SPEED(2),
        .X_START(1020), .Y_POS(100), .HOLD_FRAMES(3), .COOLDOWN_FRAMES(2)
    ) dut (
        .pixel_clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount),
        .vcount_in(vcount), .enable_in(enable), .trigger_in(trigger),
        .x_out(x), .y_out(y), .pop_out(pop), .busy_out(busy),
        .frame_tick_out(ftick)
    );

    // Second instance only to observe start-position clamping.
    sprite_pop_sequencer #(
        .SCREEN_W(1280), .SCREEN_H(720), .SPRITE_W(256), .SPEED(2),
        .X_START(2000), .Y_POS(100), .HOLD_FRAMES(3), .COOLDOWN_FRAMES(2)
    ) dut_clamp (
        .pixel_clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount),
        .vcount_in(vcount), .enable_in(enable), .trigger_in(trigger),
        .x_out(x_c), .y_out(y_c), .pop_out(pop_c), .busy_out(busy_c),
        .frame_tick_out(ftick_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] h;
        logic [9:0]  v;
        logic        en;
        logic        trig;
        logic [10:0] ex;
        logic        epop;
        logic        ebusy;
        logic        eft;
    } vec_t;

    vec_t vecs[27];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [10:0] h, input logic [9:0] v, input logic en, input logic trig);
        hcount  = h;
        vcount  = v;
        enable  = en;
        trigger = trig;
        @(posedge clk);
        #1;
    endtask

    task automatic tick_check(input logic [10:0] ex, input string name);
        drive(11'd0, 10'd720, 1'b1, 1'b0);
        check(name, 32'(x), 32'(ex));
    endtask

    initial begin
        // h, v, en, trig | x, pop, busy, frame_tick
        vecs[0]  = '{11'd5, 10'd300, 1'b1, 1'b0, 11'd1020, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{11'd0, 10'd719, 1'b1, 1'b0, 11'd1020, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{11'd1, 10'd720, 1'b1, 1'b0, 11'd1020, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{11'd0, 10'd720, 1'b1, 1'b0, 11'd1022, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{11'd5, 10'd300, 1'b1, 1'b0, 11'd1022, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{11'd0, 10'd720, 1'b1, 1'b0, 11'd1024, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{11'd0, 10'd720, 1'b1, 1'b0, 11'd1022, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{11'd0, 10'd720, 1'b0, 1'b0, 11'd1022, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{11'd5, 10'd300, 1'b1, 1'b1, 11'd1022, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{11'd5, 10'd300, 1'b1, 1'b0, 11'd1022, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{11'd0, 10'd720, 1'b1, 1'b0, 11'd1020, 1'b1, 1'b1, 1'b1};
        vecs[11] = '{11'd5, 10'd300, 1'b1, 1'b1, 11'd1020, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{11'd0, 10'd720, 1'b1, 1'b0, 11'd1020, 1'b1, 1'b1, 1'b1};
        vecs[13] = '{11'd0, 10'd720, 1'b1, 1'b0, 11'd1020, 1'b1, 1'b1, 1'b1};
        vecs[14] = '{11'd0, 10'd720, 1'b1, 1'b0, 11'd1020, 1'b0, 1'b1, 1'b1};
        vecs[15] = '{11'd5, 10'd300, 1'b1, 1'b1, 11'd1020, 1'b0, 1'b1, 1'b0};
        vecs[16] = '{11'd0, 10'd720, 1'b1, 1'b0, 11'd1018, 1'b0, 1'b1, 1'b1};
        vecs[17] = '{11'd0, 10'd720, 1'b1, 1'b0, 11'd1016, 1'b0, 1'b0, 1'b1};
        vecs[18] = '{11'd0, 10'd720, 1'b1, 1'b0, 11'd1014, 1'b0, 1'b0, 1'b1};
        vecs[19] = '{11'd0, 10'd720, 1'b1, 1'b1, 11'd1012, 1'b1, 1'b1, 1'b1};
        vecs[20] = '{11'd0, 10'd720, 1'b1, 1'b0, 11'd1012, 1'b1, 1'b1, 1'b1};
        vecs[21] = '{11'd0, 10'd720, 1'b1, 1'b0, 11'd1012, 1'b1, 1'b1, 1'b1};
        vecs[22] = '{11'd0, 10'd720, 1'b1, 1'b0, 11'd1012, 1'b0, 1'b1, 1'b1};
        vecs[23] = '{11'd0, 10'd720, 1'b1, 1'b0, 11'd1010, 1'b0, 1'b1, 1'b1};
        vecs[24] = '{11'd0, 10'd720, 1'b1, 1'b0, 11'd1008, 1'b0, 1'b0, 1'b1};
        vecs[25] = '{11'd5, 10'd300, 1'b1, 1'b1, 11'd1008, 1'b0, 1'b0, 1'b0};
        vecs[26] = '{11'd0, 10'd720, 1'b1, 1'b0, 11'd1006, 1'b1, 1'b1, 1'b1};

        // Reset held with the clock running.
        rst_n   = 1'b0;
        hcount  = 11'd5;
        vcount  = 10'd300;
        enable  = 1'b1;
        trigger = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_x", 32'(x), 32'd1020);
        check("rst_y", 32'(y), 32'd100);
        check("rst_pop", 32'(pop), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ftick", 32'(ftick), 32'd0);
        check("rst_clamp_x", 32'(x_c), 32'd1024);

        // Release without a tick: nothing moves.
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) drive(11'd5, 10'd300, 1'b1, 1'b0);
        check("rel_x", 32'(x), 32'd1020);
        check("rel_pop", 32'(pop), 32'd0);
        check("rel_busy", 32'(busy), 32'd0);
        check("rel_ftick", 32'(ftick), 32'd0);

        // Table-driven frame sequence.
        for (int i = 0; i < 27; i++) begin
            drive(vecs[i].h, vecs[i].v, vecs[i].en, vecs[i].trig);
            check($sformatf("v%0d_x", i), 32'(x), 32'(vecs[i].ex));
            check($sformatf("v%0d_pop", i), 32'(pop), 32'(vecs[i].epop));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].ebusy));
            check($sformatf("v%0d_ftick", i), 32'(ftick), 32'(vecs[i].eft));
            check($sformatf("v%0d_y", i), 32'(y), 32'd100);
        end

        // Async reset mid-POP, away from any clock edge.
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_pop", 32'(pop), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_x", 32'(x), 32'd1020);
        check("arst_ftick", 32'(ftick), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(11'd5, 10'd300, 1'b1, 1'b0);
        check("post_rst_pop", 32'(pop), 32'd0);
        drive(11'd0, 10'd720, 1'b1, 1'b0);
        check("post_rst_tick_pop", 32'(pop), 32'd0);
        check("post_rst_tick_busy", 32'(busy), 32'd0);
        check("post_rst_tick_x", 32'(x), 32'd1022);

        // Full sweep: right edge, all the way left, bounce at 0.
        tick_check(11'd1024, "sweep_right_edge");
        for (int k = 1; k <= 511; k++) begin
            tick_check(11'(1024 - 2 * k), $sformatf("sweep_left_%0d", k));
        end
        tick_check(11'd0, "sweep_left_edge");
        tick_check(11'd2, "sweep_bounce_right");
        check("sweep_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_pop_sequencer.md
Name: sprite_pop_sequencer

Overview:
- Frame-synchronous controller driving the position (x, y) and pop-frame select of the two-frame palette image sprite.
- Sits in the pixel_clk_in domain between the video timing generator (hcount/vcount) and the sprite renderer.
- Moves the sprite horizontally with edge bounce, and on a trigger event shows the "pop" half of the image for a fixed number of frames, followed by a cooldown.
- All updates occur only at the start of vertical blanking, so the renderer never changes state mid-frame (no tearing).

Parameters:
- SCREEN_W, 1280, active pixels per line.
- SCREEN_H, 720, active lines per frame.
- SPRITE_W, 256, sprite width in pixels.
- SPEED, 2, horizontal pixels moved per frame.
- X_START, 0, x position after reset.
- Y_POS, 100, constant y position output.
- HOLD_FRAMES, 30, frames pop_out stays high per trigger (≥1).
- COOLDOWN_FRAMES, 15, frames after pop during which triggers are ignored (≥1).

Ports:
- pixel_clk_in  input  1  pixel clock.
- rst_n_in  input  1  asynchronous active-low reset.
- hcount_in  input  11  current pixel column.
- vcount_in  input  10  current line.
- enable_in  input  1  motion enable; sampled at the frame tick.
- trigger_in  input  1  pop request; single-cycle pulse or level.
- x_out  output  11  sprite left edge.
- y_out  output  10  sprite top edge; constant Y_POS.
- pop_out  output  1  selects the pop image half.
- busy_out  output  1  high in POP or COOL.
- frame_tick_out  output  1  registered frame tick.

Behaviour:
- Reset (async assert, sync deassert use): x_out=X_START, y_out=Y_POS, pop_out=0, busy_out=0, frame_tick_out=0, dir=right, state=IDLE, cnt=0, trig_pending=0.
- Frame tick: tick = (hcount_in==0 && vcount_in==SCREEN_H), one cycle per frame. frame_tick_out is tick delayed 1 cycle. All state/position updates are applied on the tick edge and are visible one cycle after tick.
- Trigger latch:
  - trig_pending is set by trigger_in==1 in any cycle while state==IDLE.
  - It is cleared on every tick.
  - A trigger coincident with the tick counts for that tick.
  - Triggers in POP/COOL are discarded.
- FSM (cnt is 8 bits min, sized $clog2 of max(HOLD,COOL)+1; advances only on tick):
  - IDLE: if tick and (trig_pending or trigger_in) -> POP, cnt=HOLD_FRAMES-1, pop_out=1.
  - POP: on tick, if cnt==0 -> COOL, cnt=COOLDOWN_FRAMES-1, pop_out=0; else cnt-=1.
  - COOL: on tick, if cnt==0 -> IDLE; else cnt-=1.
  - Resulting timing: pop_out high for exactly HOLD_FRAMES ticks. IDLE is re-entered COOLDOWN_FRAMES ticks after pop_out falls.
- busy_out = (state != IDLE), registered with the state.
- Motion (on tick, only if enable_in==1 and state != POP; motion frozen while popped). XMAX = SCREEN_W - SPRITE_W.
  - dir=right: if x+SPEED >= XMAX then x=XMAX, dir=left; else x+=SPEED.
  - dir=left: if x <= SPEED then x=0, dir=right; else x-=SPEED.
  - Compare in 12-bit to avoid overflow. x_out never leaves [0, XMAX].
- X_START > XMAX is clamped to XMAX on reset.
- Reset mid-POP: pop_out falls immediately (async); FSM returns to IDLE and the pending trigger is lost.

Test Plan:
- Reset: hold rst_n_in=0 with pixel_clk_in running -> x_out=0, y_out=100, pop_out=0, busy_out=0. Release, no tick -> outputs unchanged.
- Motion/bounce (enable_in=1, X_START=1020, XMAX=1024, SPEED=2):
  - tick1 -> x=1022.
  - tick2 -> x=1024, dir=left.
  - tick3 -> x=1022.
  - With X_START=2, dir left: next tick -> x=0, dir=right, then x=2.
- Pop sequence (HOLD=3, COOL=2):
  - trigger pulse mid-frame -> pop_out rises 1 cycle after the next tick and stays high for 3 ticks; busy_out high.
  - After 2 further ticks -> busy_out=0.
  - x_out constant throughout POP.
- Trigger ignored: a pulse during POP and during COOL -> no second pop. A pulse coincident with the tick in IDLE -> pop starts at that tick.
- Tick qualification: hcount_in=0 with vcount_in=719, and vcount_in=720 with hcount_in=1 -> no update. hcount_in=0 with vcount_in=720 -> frame_tick_out pulses for exactly 1 cycle.
- Async reset asserted mid-POP, between clock edges -> pop_out=0 and busy_out=0 without waiting for a clock edge. After release, a new trigger is required to pop.
